// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared definitions for the memory port master.
//   ADDR_W_DEF / DATA_W_DEF : default byte-address and data widths
//   mem_state_t             : FSM state encoding (also exported for debug)
//   is_misaligned()         : word-alignment test on the two low address bits
package mem_if_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } mem_state_t;

    // Only whole-word accesses are performed; any nonzero low bits is an error.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_master_if.sv
// mem_port_master_if: request/response handshake plus the memory-side bus.
//   Request  : req_valid, req_ready, req_write, req_addr, req_wdata
//   Response : resp_valid, resp_ready, resp_rdata, resp_err
//   Memory   : mem_read, mem_write, address, data_in (to memory), data_out (from memory)
// Modports:
//   master : the memory port master block
//   slave  : the environment (requester, response consumer and memory)
//
// Handshake rule for both req and resp channels: a transfer happens on a
// rising edge where valid and ready are both 1; the producer holds valid and
// its payload unchanged until that edge, and ready never waits on a future
// valid-free condition.
interface mem_port_master_if #(
    parameter int ADDR_W = mem_if_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_if_pkg::DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, address, data_in
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, address, data_in
    );

endinterface

// File: rtl/mem_port_master.sv
// mem_port_master: turns one request at a time into memory strobes and a
// single response.
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   bus       : mem_port_master_if.master (request, response and memory bus)
//   state_dbg : current FSM state
// Transaction flow: IDLE -> WRITE -> RESP for writes, IDLE -> READ -> CAPTURE
// -> RESP for reads, IDLE -> RESP for misaligned requests (no strobes).
// All outputs are registers so they change only on clock edges or reset.
module mem_port_master
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_master_if.master  bus,
    output mem_state_t         state_dbg
);

    mem_state_t        state;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] data_in_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            data_in_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is 1 exactly in IDLE, so req_valid here is an accept.
                    if (bus.req_valid) begin
                        req_ready_q  <= 1'b0;
                        resp_rdata_q <= '0;
                        if (is_misaligned(bus.req_addr[1:0])) begin
                            // Address/data_in are left alone: no strobe goes out.
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (bus.req_write) begin
                            state       <= WRITE;
                            resp_err_q  <= 1'b0;
                            mem_write_q <= 1'b1;
                            address_q   <= bus.req_addr;
                            data_in_q   <= bus.req_wdata;
                        end else begin
                            state      <= READ;
                            resp_err_q <= 1'b0;
                            mem_read_q <= 1'b1;
                            address_q  <= bus.req_addr;
                        end
                    end
                end

                WRITE: begin
                    // One-cycle write strobe; the memory commits at this edge.
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end

                READ: begin
                    // Memory registers data_out at this edge; keep mem_read up
                    // through CAPTURE so the address phase stays unambiguous.
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    mem_read_q   <= 1'b0;
                    resp_rdata_q <= bus.data_out;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end

                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.address    = address_q;
    assign bus.data_in    = data_in_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: directed bench for mem_port_master with a word memory
// responder, a transaction-level reference model and literal expectations.
module tb_mem_port_master;
    import mem_if_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NWORDS = 1 << (AW - 2);

    logic       clock;
    logic       reset;
    mem_state_t state_dbg;
    int         tests = 0;
    int         fails = 0;

    mem_port_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void note_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endfunction

    // ---------------- memory responder ----------------
    logic [DW-1:0] mem_words [NWORDS];
    bit            mem_loaded = 1'b0;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < NWORDS; i++) mem_words[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (bus.mem_write) mem_words[bus.address[AW-1:2]] <= bus.data_in;
            if (bus.mem_read)  bus.data_out <= mem_words[bus.address[AW-1:2]];
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction view: an accepted request occupies the block until its
    // response handshake; response appears after 1/2/3 edges (error/write/read)
    // counting the accept edge; strobes occupy the first edge window(s).
    initial begin : compare_proc
        logic [DW-1:0] model_mem [NWORDS];
        int            cyc, acc_cyc, cur_lat, lat_now;
        bit            busy, acc_pend, hs_pend, cur_wr, cur_err, exp_rv, pend_wr;
        logic [AW-1:0] pend_addr, exp_address;
        logic [DW-1:0] pend_wdata, cur_rdata, exp_data_in;
        for (int i = 0; i < NWORDS; i++) model_mem[i] = init_word(i);
        cyc = 0; acc_cyc = 0; cur_lat = 1;
        busy = 0; acc_pend = 0; hs_pend = 0; cur_wr = 0; cur_err = 0; pend_wr = 0;
        pend_addr = '0; pend_wdata = '0; cur_rdata = '0;
        exp_address = '0; exp_data_in = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                busy = 0; acc_pend = 0; hs_pend = 0;
                exp_address = '0; exp_data_in = '0;
            end else begin
                if (hs_pend) begin busy = 0; hs_pend = 0; end
                if (acc_pend) begin
                    acc_pend = 0;
                    busy     = 1;
                    acc_cyc  = cyc;
                    cur_wr   = pend_wr;
                    cur_err  = (pend_addr % 4) != 0;
                    cur_lat  = cur_err ? 1 : (cur_wr ? 2 : 3);
                    cur_rdata = (cur_err || cur_wr) ? '0 : model_mem[pend_addr / 4];
                    if (!cur_err) begin
                        exp_address = pend_addr;
                        if (cur_wr) begin
                            model_mem[pend_addr / 4] = pend_wdata;
                            exp_data_in = pend_wdata;
                        end
                    end
                end
            end
            lat_now = cyc - acc_cyc + 1;
            exp_rv  = busy && (lat_now >= cur_lat);

            check("req_ready", 32'(bus.req_ready), 32'(!busy));
            check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("resp_err", 32'(bus.resp_err), 32'(cur_err));
                check("resp_rdata", bus.resp_rdata, cur_rdata);
            end
            if (reset) begin
                check("rst_resp_err", 32'(bus.resp_err), 32'd0);
                check("rst_resp_rdata", bus.resp_rdata, 32'd0);
            end
            check("mem_write", 32'(bus.mem_write),
                  32'(busy && !cur_err && cur_wr && lat_now == 1));
            check("mem_read", 32'(bus.mem_read),
                  32'(busy && !cur_err && !cur_wr && (lat_now == 1 || lat_now == 2)));
            check("strobe_excl", 32'(bus.mem_read && bus.mem_write), 32'd0);
            check("address", 32'(bus.address), 32'(exp_address));
            check("data_in", bus.data_in, exp_data_in);

            if (!reset) begin
                if (!busy && bus.req_valid) begin
                    acc_pend   = 1;
                    pend_wr    = bus.req_write;
                    pend_addr  = bus.req_addr;
                    pend_wdata = bus.req_wdata;
                end
                if (exp_rv && bus.resp_ready) hs_pend = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called and returns at one time unit after a rising edge, with the block idle.
    task automatic do_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold, output logic [DW-1:0] rd, output logic er,
                          output int lat, output int nwr, output int nrd);
        int budget;
        rd = '0; er = 1'b0; lat = 0; nwr = 0; nrd = 0;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.resp_ready = (hold == 0);
        budget = 0;
        while (!bus.req_ready && budget < 20) begin step(); budget++; end
        if (!bus.req_ready) begin
            note_fail("accept_wait");
            bus.req_valid = 1'b0;
            bus.resp_ready = 1'b1;
            return;
        end
        step();
        bus.req_valid = 1'b0;
        lat = 1;
        budget = 0;
        forever begin
            nwr += int'(bus.mem_write);
            nrd += int'(bus.mem_read);
            if (bus.resp_valid || budget >= 20) break;
            step();
            lat++;
            budget++;
        end
        if (!bus.resp_valid) begin
            note_fail("resp_wait");
            bus.resp_ready = 1'b1;
            return;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        step();
    endtask

    // ---------------- directed stimulus ----------------
    logic [DW-1:0] rd;
    logic          er;
    int            lat, nwr, nrd;
    logic [DW-1:0] rd_lit [4];
    logic [AW-1:0] ra;

    initial begin
        rd_lit = '{32'h1000_0000, 32'h1000_0101, 32'h1000_0202, 32'h1000_0303};
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;

        // Write then read back 0x20.
        do_txn(1'b1, 8'h20, 32'h0000_024D, 0, rd, er, lat, nwr, nrd);
        check("wr20_lat", 32'(lat), 32'd2);
        check("wr20_nwr", 32'(nwr), 32'd1);
        check("wr20_err", 32'(er), 32'd0);
        do_txn(1'b0, 8'h20, 32'h0, 0, rd, er, lat, nwr, nrd);
        check("rd20_data", rd, 32'h0000_024D);
        check("rd20_err", 32'(er), 32'd0);
        check("rd20_lat", 32'(lat), 32'd3);
        check("rd20_nrd", 32'(nrd), 32'd2);

        // Sequential reads of the preloaded words.
        for (int i = 0; i < 4; i++) begin
            ra = 8'(i * 4);
            do_txn(1'b0, ra, 32'h0, 0, rd, er, lat, nwr, nrd);
            check("rdseq_lat", 32'(lat), 32'd3);
            check("rdseq_data", rd, rd_lit[i]);
        end

        // Misaligned read.
        do_txn(1'b0, 8'h22, 32'h0, 0, rd, er, lat, nwr, nrd);
        check("mis_rd_err", 32'(er), 32'd1);
        check("mis_rd_data", rd, 32'd0);
        check("mis_rd_lat", 32'(lat), 32'd1);
        check("mis_rd_strobes", 32'(nwr + nrd), 32'd0);

        // Misaligned write must leave memory untouched.
        do_txn(1'b1, 8'h21, 32'hDEAD_BEEF, 0, rd, er, lat, nwr, nrd);
        check("mis_wr_err", 32'(er), 32'd1);
        check("mis_wr_strobes", 32'(nwr + nrd), 32'd0);
        do_txn(1'b0, 8'h20, 32'h0, 0, rd, er, lat, nwr, nrd);
        check("rd20_after_mis", rd, 32'h0000_024D);

        // Response back-pressure for 5 cycles.
        do_txn(1'b0, 8'h08, 32'h0, 5, rd, er, lat, nwr, nrd);
        check("hold_data", rd, 32'h1000_0202);
        check("hold_lat", 32'(lat), 32'd3);

        // A few more write/read pairs.
        for (int i = 0; i < 4; i++) begin
            ra = 8'h40 + 8'(i * 4);
            do_txn(1'b1, ra, 32'hA5A5_0000 + 32'(i), 0, rd, er, lat, nwr, nrd);
            do_txn(1'b0, ra, 32'h0, 0, rd, er, lat, nwr, nrd);
            check("wrrd_loop_data", rd, 32'hA5A5_0000 + 32'(i));
        end

        // Reset in CAPTURE mid-read.
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h30; bus.resp_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        check("pre_rst_state", 32'(state_dbg), 32'(CAPTURE));
        #2 reset = 1'b1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_data_in", bus.data_in, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        do_txn(1'b1, 8'h24, 32'hCAFE_0024, 0, rd, er, lat, nwr, nrd);
        check("wr24_lat", 32'(lat), 32'd2);
        check("wr24_err", 32'(er), 32'd0);
        do_txn(1'b0, 8'h24, 32'h0, 0, rd, er, lat, nwr, nrd);
        check("rd24_data", rd, 32'hCAFE_0024);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
